// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: bench-side UART receiver for the uart_0_tx pin.
// Deserialises 8N1 frames into bytes, or 8E1 frames when the macro
// UART_RX_MONITOR_PARITY_EN is defined. Received bytes go into a small
// first-word fall-through FIFO with a valid/ready handshake. Line errors
// raise one-cycle pulses and bump a saturating error counter. A dropped
// byte sets a sticky overflow flag.
module uart_rx_monitor #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_busy,
   output logic       o_frame_err,
   output logic       o_parity_err,
   output logic       o_overflow,
   output logic [7:0] o_err_count,
   input  logic       i_clr
);

   localparam int CW    = $clog2(CLKS_PER_BIT);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = AW + 1;
   localparam logic [CW-1:0]    TICK_VAL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]    HALF_VAL = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_VAL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          par_bad;

   logic rx_meta, rx_s, rx_prev;
   logic fall, tick, stop_tick, push, err_evt;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full, pop, wr_en, ovf_evt;

   // Two-flop synchroniser plus one history flop for falling-edge detect.
   // NOTE: these reset to 1 (idle line level) so leaving reset never looks like a start bit.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign fall      = rx_prev & ~rx_s;
   assign tick      = (cnt == TICK_VAL);
   assign stop_tick = (state == STOP) && tick;
   // NOTE: push is combinational from the STOP tick so the byte lands in the FIFO at the end of that same cycle.
   assign push      = stop_tick & rx_s & ~par_bad;
   assign err_evt   = stop_tick & (~rx_s | par_bad);
   assign o_busy    = (state != IDLE);

   // Receiver FSM: bit timing, shifting, and the registered error pulses.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         o_frame_err <= 1'b0;
`ifdef UART_RX_MONITOR_PARITY_EN
         par_bad      <= 1'b0;
         o_parity_err <= 1'b0;
`endif
      end else begin
         o_frame_err <= 1'b0;
`ifdef UART_RX_MONITOR_PARITY_EN
         o_parity_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               cnt <= '0;
               if (fall) state <= START;
            end
            START: begin
               if (cnt == HALF_VAL) begin
                  cnt     <= '0;
                  bit_idx <= '0;
`ifdef UART_RX_MONITOR_PARITY_EN
                  par_bad <= 1'b0;
`endif
                  state   <= rx_s ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (tick) begin
                  cnt     <= '0;
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_MONITOR_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_RX_MONITOR_PARITY_EN
            PARITY: begin
               if (tick) begin
                  cnt     <= '0;
                  par_bad <= rx_s ^ (^shreg);
                  state   <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  cnt   <= '0;
                  state <= IDLE;
                  if (!rx_s) begin
                     o_frame_err <= 1'b1;
`ifdef UART_RX_MONITOR_PARITY_EN
                  end else if (par_bad) begin
                     o_parity_err <= 1'b1;
`endif
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef UART_RX_MONITOR_PARITY_EN
   assign par_bad      = 1'b0;
   assign o_parity_err = 1'b0;
`endif

   assign pop     = o_valid & i_ready;
   assign full    = (count == FULL_VAL);
   assign wr_en   = push & (~full | pop);
   assign ovf_evt = push & full & ~pop;
   assign o_valid = (count != '0);
   assign o_data  = o_valid ? mem[rd_ptr] : 8'h00;

   // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage write port.
   // NOTE: storage has no reset; empty pointers plus the o_valid gate on o_data hide stale contents.
   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wr_ptr] <= shreg;
   end

   // Sticky overflow flag and saturating error counter; a same-cycle event beats i_clr.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_overflow  <= 1'b0;
         o_err_count <= 8'd0;
      end else begin
         if (ovf_evt)    o_overflow <= 1'b1;
         else if (i_clr) o_overflow <= 1'b0;

         if (err_evt) begin
            if (i_clr)                     o_err_count <= 8'd1;
            else if (o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
         end else if (i_clr) begin
            o_err_count <= 8'd0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: drives UART frames into uart_rx_monitor and checks
// every output on every cycle against a frame-level reference model.
// The model predicts each frame's outcome cycle from the line timing and
// keeps the expected FIFO contents in a queue. It follows the DUT build
// through UART_RX_MONITOR_PARITY_EN.
module tb_uart_rx_monitor;

   localparam int C     = 16;
   localparam int HALF  = C / 2;
   localparam int DEPTH = 4;
`ifdef UART_RX_MONITOR_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, ready = 1'b1, clr = 1'b0;
   logic [7:0] data, err_count;
   logic       valid, busy, frame_err, parity_err, overflow;

   uart_rx_monitor #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst), .i_rx(rx),
      .o_data(data), .o_valid(valid), .i_ready(ready), .o_busy(busy),
      .o_frame_err(frame_err), .o_parity_err(parity_err),
      .o_overflow(overflow), .o_err_count(err_count), .i_clr(clr)
   );

   always #5 clk = ~clk;

   int unsigned edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   typedef enum {EV_GLITCH, EV_BYTE, EV_FRAME, EV_PARITY, EV_ABORT} ev_kind_t;
   typedef struct {
      int unsigned t_busy;
      int unsigned t_end;
      ev_kind_t    kind;
      logic [7:0]  byte_val;
   } ev_t;

   ev_t         evq[$];
   ev_t         keep[$];
   logic [7:0]  mq[$];
   logic [7:0]  rx_log[$];
   bit          m_ovf, pop_pend, clr_pend, e_ferr, e_perr, e_busy;
   int unsigned m_err;
   int          n_checks = 0, n_fail = 0, n_ferr = 0, n_perr = 0;
   bit          rnd_en = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) tick();
   endtask

   // Sends one frame; the outcome becomes visible after edge t_end.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_wrong);
      ev_t e;
      tick();
      e.t_busy   = edge_n + 3;
      e.t_end    = edge_n + 3 + HALF + (9 + PAR) * C;
      e.byte_val = b;
      if (!stop_ok)                 e.kind = EV_FRAME;
      else if (PAR == 1 && par_wrong) e.kind = EV_PARITY;
      else                          e.kind = EV_BYTE;
      evq.push_back(e);
      hold(1'b0, C);
      for (int i = 0; i < 8; i++) hold(b[i], C);
      if (PAR == 1) hold((^b) ^ par_wrong, C);
      hold(stop_ok, C);
      rx = 1'b1;
   endtask

   task automatic send_glitch(input int len);
      ev_t e;
      tick();
      e.t_busy   = edge_n + 3;
      e.t_end    = edge_n + 3 + HALF;
      e.kind     = EV_GLITCH;
      e.byte_val = 8'h00;
      evq.push_back(e);
      hold(1'b0, len);
      hold(1'b1, HALF + 8);
   endtask

   // Reference model and per-cycle comparison, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         mq.delete();
         evq.delete();
         m_ovf    = 0;
         m_err    = 0;
         pop_pend = 0;
         clr_pend = 0;
         check("rst_valid", valid, 0);
         check("rst_data", data, 0);
         check("rst_busy", busy, 0);
         check("rst_ferr", frame_err, 0);
         check("rst_perr", parity_err, 0);
         check("rst_ovf", overflow, 0);
         check("rst_errcnt", err_count, 0);
      end else begin
         e_ferr = 0;
         e_perr = 0;
         e_busy = 0;
         keep.delete();
         if (pop_pend) void'(mq.pop_front());
         if (clr_pend) begin
            m_ovf = 0;
            m_err = 0;
         end
         foreach (evq[i]) begin
            if (evq[i].t_end == edge_n) begin
               case (evq[i].kind)
                  EV_BYTE: begin
                     if (mq.size() < DEPTH) mq.push_back(evq[i].byte_val);
                     else                   m_ovf = 1;
                  end
                  EV_FRAME: begin
                     e_ferr = 1;
                     if (m_err < 255) m_err++;
                  end
                  EV_PARITY: begin
                     e_perr = 1;
                     if (m_err < 255) m_err++;
                  end
                  default: ;
               endcase
            end
            if (evq[i].t_busy <= edge_n && edge_n < evq[i].t_end) e_busy = 1;
            if (evq[i].t_end > edge_n) keep.push_back(evq[i]);
         end
         evq = keep;

         check("valid", valid, (mq.size() != 0));
         if (mq.size() != 0) check("data", data, mq[0]);
         check("busy", busy, e_busy);
         check("frame_err", frame_err, e_ferr);
         check("parity_err", parity_err, e_perr);
         check("overflow", overflow, m_ovf);
         check("err_count", err_count, m_err);

         if (valid && ready) rx_log.push_back(data);
         if (frame_err)  n_ferr++;
         if (parity_err) n_perr++;
         pop_pend = (mq.size() != 0) && ready;
         clr_pend = clr;
      end
   end

   // Random consumer back-pressure and occasional clears during the random phase.
   always @(posedge clk) begin
      if (rnd_en) begin
         #1;
         ready = ($urandom_range(0, 3) != 0);
         clr   = ($urandom_range(0, 63) == 0);
      end
   end

   initial begin
      int base;
      int sel;
      logic [7:0] b;

      repeat (3) tick();
      rst = 1'b0;
      repeat (4) tick();

      // Two clean frames.
      send_frame(8'h55, 1, 0);
      send_frame(8'hA3, 1, 0);
      repeat (4) tick();
      check("s1_count", rx_log.size(), 2);
      check("s1_byte0", rx_log[0], 8'h55);
      check("s1_byte1", rx_log[1], 8'hA3);

      // Short low pulse aborts in START.
      send_glitch(5);
      @(negedge clk);
      check("glitch_busy", busy, 0);
      check("glitch_valid", valid, 0);
      check("glitch_errcnt", err_count, 0);

      // Bad stop bit, then recovery once the line is high again.
      send_frame(8'hA3, 0, 0);
      hold(1'b1, 4);
      send_frame(8'h7E, 1, 0);
      repeat (4) tick();
      check("ferr_pulses", n_ferr, 1);
      check("ferr_errcnt", err_count, 1);
      check("ferr_count", rx_log.size(), 3);
      check("ferr_next", rx_log[2], 8'h7E);

      // Overflow with the consumer stalled.
      ready = 1'b0;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1, 0);
      repeat (2) tick();
      check("ovf_flag", overflow, 1);
      check("ovf_head", data, 8'h01);
      base  = rx_log.size();
      ready = 1'b1;
      repeat (8) tick();
      check("ovf_drain", rx_log.size() - base, 4);
      for (int i = 0; i < 4; i++) check("ovf_order", rx_log[base + i], 8'(i + 1));
      check("ovf_empty", valid, 0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick();
      check("clr_ovf", overflow, 0);
      check("clr_errcnt", err_count, 0);

      // Reset in the middle of a frame, with a byte waiting in the FIFO.
      ready = 1'b0;
      send_frame(8'h11, 1, 0);
      tick();
      check("pre_rst_valid", valid, 1);
      begin
         ev_t e;
         e.t_busy   = edge_n + 3;
         e.t_end    = edge_n + 100000;
         e.kind     = EV_ABORT;
         e.byte_val = 8'h00;
         evq.push_back(e);
      end
      hold(1'b0, C);
      for (int i = 0; i < 4; i++) hold(1'b0, C);
      hold(1'b1, HALF);
      rst = 1'b1;
      tick();
      @(negedge clk);
      check("mid_rst_valid", valid, 0);
      tick();
      rst   = 1'b0;
      ready = 1'b1;
      hold(1'b1, 2 * C);
      base = rx_log.size();
      send_frame(8'h3C, 1, 0);
      repeat (4) tick();
      check("rst_count", rx_log.size() - base, 1);
      check("rst_byte", rx_log[base], 8'h3C);

`ifdef UART_RX_MONITOR_PARITY_EN
      // Even parity of 0x07 is 1: a 0 parity bit is an error.
      base = rx_log.size();
      send_frame(8'h07, 1, 1);
      repeat (4) tick();
      check("par_pulses", n_perr, 1);
      check("par_errcnt", err_count, 1);
      check("par_nobyte", rx_log.size() - base, 0);
      send_frame(8'h07, 1, 0);
      repeat (4) tick();
      check("par_good", rx_log[base], 8'h07);
`endif

      // Randomised traffic: clean frames, bad stop bits, bad parity, glitches.
      rnd_en = 1;
      for (int k = 0; k < 40; k++) begin
         sel = $urandom_range(0, 9);
         b   = 8'($urandom);
         if (sel == 0) begin
            send_glitch($urandom_range(1, HALF));
         end else begin
            send_frame(b, (sel != 1), (sel == 2));
            hold(1'b1, $urandom_range(2, 8));
         end
      end
      rnd_en = 0;
      #2;
      ready = 1'b1;
      clr   = 1'b0;
      repeat (20) tick();
      @(negedge clk);
      check("final_empty", valid, 0);
      check("final_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
